// File: rtl/letc_core_mem_arb.sv
// Round-robin arbiter sharing one downstream memory channel between IMSS (read-only)
// and DMSS (read/write), with a single transaction outstanding at a time.
module letc_core_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  imss_req_valid,
    output logic                  imss_req_ready,
    input  logic [ADDR_W-1:0]     imss_req_addr,
    output logic                  imss_rsp_valid,
    output logic [DATA_W-1:0]     imss_rsp_rdata,
    output logic                  imss_rsp_err,

    input  logic                  dmss_req_valid,
    output logic                  dmss_req_ready,
    input  logic [ADDR_W-1:0]     dmss_req_addr,
    input  logic                  dmss_req_wen,
    input  logic [DATA_W-1:0]     dmss_req_wdata,
    input  logic [DATA_W/8-1:0]   dmss_req_wstrb,
    output logic                  dmss_rsp_valid,
    output logic [DATA_W-1:0]     dmss_rsp_rdata,
    output logic                  dmss_rsp_err,

    output logic                  down_req_valid,
    input  logic                  down_req_ready,
    output logic [ADDR_W-1:0]     down_req_addr,
    output logic                  down_req_wen,
    output logic [DATA_W-1:0]     down_req_wdata,
    output logic [DATA_W/8-1:0]   down_req_wstrb,
    input  logic                  down_rsp_valid,
    input  logic [DATA_W-1:0]     down_rsp_rdata,
    input  logic                  down_rsp_err,

    output logic [1:0]            dbg_state,
    output logic                  dbg_owner
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              grant_any;
    logic              grant_dmss;
    logic              in_idle;

    // On a tie DMSS wins only when IMSS held the previous grant (last_grant = 0).
    assign grant_any  = imss_req_valid | dmss_req_valid;
    assign grant_dmss = dmss_req_valid & (~imss_req_valid | ~last_grant_q);
    assign in_idle    = (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d      = grant_dmss;
                    last_grant_d = grant_dmss;
                    state_d      = ST_REQ;
                    if (grant_dmss) begin
                        addr_d  = dmss_req_addr;
                        wen_d   = dmss_req_wen;
                        wdata_d = dmss_req_wdata;
                        wstrb_d = dmss_req_wstrb;
                    end else begin
                        addr_d  = imss_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (down_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (down_rsp_valid) begin
                    rdata_d = wen_q ? '0 : down_rsp_rdata;
                    err_d   = down_rsp_err;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign imss_req_ready = in_idle & imss_req_valid & ~grant_dmss;
    assign dmss_req_ready = in_idle & grant_dmss;

    assign imss_rsp_valid = (state_q == ST_DONE) & ~owner_q;
    assign dmss_rsp_valid = (state_q == ST_DONE) & owner_q;
    assign imss_rsp_rdata = rdata_q;
    assign dmss_rsp_rdata = rdata_q;
    assign imss_rsp_err   = err_q;
    assign dmss_rsp_err   = err_q;

    assign down_req_valid = (state_q == ST_REQ);
    assign down_req_addr  = addr_q;
    assign down_req_wen   = wen_q;
    assign down_req_wdata = wdata_q;
    assign down_req_wstrb = wstrb_q;

    assign dbg_state = state_q;
    assign dbg_owner = owner_q;

endmodule

// File: tb/tb_letc_core_mem_arb.sv
// Directed self-checking bench for letc_core_mem_arb; the bench plays the role of
// both requesters and the downstream memory channel.
module tb_letc_core_mem_arb;

    logic        clk;
    logic        rst_n;
    logic        imss_req_valid;
    logic        imss_req_ready;
    logic [31:0] imss_req_addr;
    logic        imss_rsp_valid;
    logic [31:0] imss_rsp_rdata;
    logic        imss_rsp_err;
    logic        dmss_req_valid;
    logic        dmss_req_ready;
    logic [31:0] dmss_req_addr;
    logic        dmss_req_wen;
    logic [31:0] dmss_req_wdata;
    logic [3:0]  dmss_req_wstrb;
    logic        dmss_rsp_valid;
    logic [31:0] dmss_rsp_rdata;
    logic        dmss_rsp_err;
    logic        down_req_valid;
    logic        down_req_ready;
    logic [31:0] down_req_addr;
    logic        down_req_wen;
    logic [31:0] down_req_wdata;
    logic [3:0]  down_req_wstrb;
    logic        down_rsp_valid;
    logic [31:0] down_rsp_rdata;
    logic        down_rsp_err;
    logic [1:0]  dbg_state;
    logic        dbg_owner;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-transaction observations filled by run_txn
    logic        r_gnt_i, r_gnt_d, r_wen, r_stable, r_busy_rdy, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    int          r_lat, r_ipulse, r_dpulse;

    letc_core_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imss_req_valid (imss_req_valid),
        .imss_req_ready (imss_req_ready),
        .imss_req_addr  (imss_req_addr),
        .imss_rsp_valid (imss_rsp_valid),
        .imss_rsp_rdata (imss_rsp_rdata),
        .imss_rsp_err   (imss_rsp_err),
        .dmss_req_valid (dmss_req_valid),
        .dmss_req_ready (dmss_req_ready),
        .dmss_req_addr  (dmss_req_addr),
        .dmss_req_wen   (dmss_req_wen),
        .dmss_req_wdata (dmss_req_wdata),
        .dmss_req_wstrb (dmss_req_wstrb),
        .dmss_rsp_valid (dmss_rsp_valid),
        .dmss_rsp_rdata (dmss_rsp_rdata),
        .dmss_rsp_err   (dmss_rsp_err),
        .down_req_valid (down_req_valid),
        .down_req_ready (down_req_ready),
        .down_req_addr  (down_req_addr),
        .down_req_wen   (down_req_wen),
        .down_req_wdata (down_req_wdata),
        .down_req_wstrb (down_req_wstrb),
        .down_rsp_valid (down_rsp_valid),
        .down_rsp_rdata (down_rsp_rdata),
        .down_rsp_err   (down_rsp_err),
        .dbg_state      (dbg_state),
        .dbg_owner      (dbg_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for two edges; returns 1 time unit after a rising edge with rst_n released.
    task automatic do_reset();
        rst_n          = 1'b0;
        imss_req_valid = 1'b0;
        imss_req_addr  = '0;
        dmss_req_valid = 1'b0;
        dmss_req_addr  = '0;
        dmss_req_wen   = 1'b0;
        dmss_req_wdata = '0;
        dmss_req_wstrb = '0;
        down_req_ready = 1'b0;
        down_rsp_valid = 1'b0;
        down_rsp_rdata = '0;
        down_rsp_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one request (cycle 0 = accept), models the downstream with the given
    // stall counts, and records what the requesters and the downstream observed.
    task automatic run_txn(
        input  logic        iv,
        input  logic        dv,
        input  logic [31:0] ia,
        input  logic [31:0] da,
        input  logic        dwen,
        input  logic [31:0] dwd,
        input  logic [3:0]  dws,
        input  int          req_stall,
        input  int          rsp_stall,
        input  logic [31:0] rd,
        input  logic        er
    );
        int   phase;
        int   req_cnt;
        int   rsp_cnt;
        int   cyc;
        logic seen;
        bit   done;
        imss_req_valid = iv;
        imss_req_addr  = ia;
        dmss_req_valid = dv;
        dmss_req_addr  = da;
        dmss_req_wen   = dwen;
        dmss_req_wdata = dwd;
        dmss_req_wstrb = dws;
        down_req_ready = 1'b0;
        down_rsp_valid = 1'b0;
        @(negedge clk);
        r_gnt_i    = imss_req_ready;
        r_gnt_d    = dmss_req_ready;
        r_lat      = -1;
        r_ipulse   = 0;
        r_dpulse   = 0;
        r_stable   = 1'b1;
        r_busy_rdy = 1'b0;
        r_addr     = '0;
        r_wen      = 1'b0;
        r_wdata    = '0;
        r_wstrb    = '0;
        r_rdata    = '0;
        r_err      = 1'b0;
        seen       = 1'b0;
        phase      = 0;
        req_cnt    = 0;
        rsp_cnt    = 0;
        cyc        = 0;
        done       = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            down_req_ready = 1'b0;
            down_rsp_valid = 1'b0;
            down_rsp_rdata = '0;
            down_rsp_err   = 1'b0;
            if (phase == 0) begin
                if (down_req_valid) begin
                    if (!seen) begin
                        seen    = 1'b1;
                        r_addr  = down_req_addr;
                        r_wen   = down_req_wen;
                        r_wdata = down_req_wdata;
                        r_wstrb = down_req_wstrb;
                    end else if ({down_req_addr, down_req_wen, down_req_wdata, down_req_wstrb}
                                 !== {r_addr, r_wen, r_wdata, r_wstrb}) begin
                        r_stable = 1'b0;
                    end
                    if (req_cnt == req_stall) begin
                        down_req_ready = 1'b1;
                        phase = 1;
                    end else begin
                        req_cnt++;
                    end
                end else if (seen) begin
                    r_stable = 1'b0;
                end
            end else if (phase == 1) begin
                if (rsp_cnt == rsp_stall) begin
                    down_rsp_valid = 1'b1;
                    down_rsp_rdata = rd;
                    down_rsp_err   = er;
                    phase = 2;
                end else begin
                    rsp_cnt++;
                end
            end
            @(negedge clk);
            if (imss_req_ready || dmss_req_ready) r_busy_rdy = 1'b1;
            if (imss_rsp_valid) begin
                r_ipulse++;
                r_lat   = cyc;
                r_rdata = imss_rsp_rdata;
                r_err   = imss_rsp_err;
            end
            if (dmss_rsp_valid) begin
                r_dpulse++;
                r_lat   = cyc;
                r_rdata = dmss_rsp_rdata;
                r_err   = dmss_rsp_err;
            end
            if (r_ipulse + r_dpulse > 0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        imss_req_valid = 1'b0;
        dmss_req_valid = 1'b0;
        down_req_ready = 1'b0;
        down_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imss_req_valid = 1'b0;
        dmss_req_valid = 1'b0;
        down_req_ready = 1'b0;
        down_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        n_cmp++; if (dbg_owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner got=%0b exp=0", dbg_owner); end
        n_cmp++; if ({imss_req_ready, dmss_req_ready, imss_rsp_valid, dmss_rsp_valid, imss_rsp_err, dmss_rsp_err, down_req_valid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000000", {imss_req_ready, dmss_req_ready, imss_rsp_valid, dmss_rsp_valid, imss_rsp_err, dmss_rsp_err, down_req_valid});
        end
        n_cmp++; if ({down_req_addr, down_req_wen, down_req_wdata, down_req_wstrb, imss_rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_payload got addr=%h wdata=%h wstrb=%h rdata=%h exp=0", down_req_addr, down_req_wdata, down_req_wstrb, imss_rsp_rdata);
        end
        do_reset();
    endtask

    task automatic test_imss_read();
        run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (r_gnt_i !== 1'b1 || r_gnt_d !== 1'b0) begin n_fail++; $display("FAIL imss_grant got i=%0b d=%0b exp i=1 d=0", r_gnt_i, r_gnt_d); end
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL imss_latency got=%0d exp=3", r_lat); end
        n_cmp++; if (r_ipulse !== 1 || r_dpulse !== 0) begin n_fail++; $display("FAIL imss_route got i=%0d d=%0d exp i=1 d=0", r_ipulse, r_dpulse); end
        n_cmp++; if (r_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL imss_rdata got=%h exp=deadbeef", r_rdata); end
        n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL imss_err got=%0b exp=0", r_err); end
        n_cmp++; if (r_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL imss_down_addr got=%h exp=00001000", r_addr); end
        n_cmp++; if (r_wen !== 1'b0 || r_wstrb !== 4'h0) begin n_fail++; $display("FAIL imss_down_wen got wen=%0b wstrb=%h exp 0/0", r_wen, r_wstrb); end
        @(negedge clk);
        n_cmp++; if (imss_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL imss_pulse_width got=%0b exp=0", imss_rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_dmss_write();
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_2004, 1'b1, 32'h1234_5678, 4'hC, 0, 0, 32'hFFFF_FFFF, 1'b0);
        n_cmp++; if (r_gnt_d !== 1'b1 || r_gnt_i !== 1'b0) begin n_fail++; $display("FAIL dmss_grant got i=%0b d=%0b exp i=0 d=1", r_gnt_i, r_gnt_d); end
        n_cmp++; if (r_addr !== 32'h0000_2004) begin n_fail++; $display("FAIL dmss_down_addr got=%h exp=00002004", r_addr); end
        n_cmp++; if (r_wen !== 1'b1) begin n_fail++; $display("FAIL dmss_down_wen got=%0b exp=1", r_wen); end
        n_cmp++; if (r_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dmss_down_wdata got=%h exp=12345678", r_wdata); end
        n_cmp++; if (r_wstrb !== 4'hC) begin n_fail++; $display("FAIL dmss_down_wstrb got=%h exp=c", r_wstrb); end
        n_cmp++; if (r_dpulse !== 1 || r_ipulse !== 0) begin n_fail++; $display("FAIL dmss_route got i=%0d d=%0d exp i=0 d=1", r_ipulse, r_dpulse); end
        n_cmp++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL dmss_write_rdata got=%h exp=00000000", r_rdata); end
        n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL dmss_latency got=%0d exp=3", r_lat); end
    endtask

    task automatic test_req_stall();
        // Last grant was DMSS, so the tie goes to IMSS; DMSS keeps requesting throughout.
        run_txn(1'b1, 1'b1, 32'h0000_3000, 32'h0000_3100, 1'b0, 32'h0, 4'h0, 5, 0, 32'hA5A5_0001, 1'b0);
        n_cmp++; if (r_gnt_i !== 1'b1 || r_gnt_d !== 1'b0) begin n_fail++; $display("FAIL stall_grant got i=%0b d=%0b exp i=1 d=0", r_gnt_i, r_gnt_d); end
        n_cmp++; if (r_lat !== 8) begin n_fail++; $display("FAIL stall_latency got=%0d exp=8", r_lat); end
        n_cmp++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL stall_payload_stable got=%0b exp=1", r_stable); end
        n_cmp++; if (r_busy_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready got=%0b exp=0", r_busy_rdy); end
        n_cmp++; if (r_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL stall_down_addr got=%h exp=00003000", r_addr); end
        n_cmp++; if (r_rdata !== 32'hA5A5_0001 || r_ipulse !== 1) begin n_fail++; $display("FAIL stall_rsp got rdata=%h ipulse=%0d exp a5a50001/1", r_rdata, r_ipulse); end
    endtask

    task automatic test_err_and_spurious();
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_4000, 1'b0, 32'h0, 4'hF, 0, 2, 32'h0BAD_0BAD, 1'b1);
        n_cmp++; if (r_dpulse !== 1 || r_ipulse !== 0) begin n_fail++; $display("FAIL err_route got i=%0d d=%0d exp i=0 d=1", r_ipulse, r_dpulse); end
        n_cmp++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%0b exp=1", r_err); end
        n_cmp++; if (r_rdata !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL err_rdata got=%h exp=0bad0bad", r_rdata); end
        n_cmp++; if (r_lat !== 5) begin n_fail++; $display("FAIL err_latency got=%0d exp=5", r_lat); end
        // Spurious downstream response while idle
        down_rsp_valid = 1'b1;
        down_rsp_rdata = 32'h5555_5555;
        down_rsp_err   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (imss_rsp_valid !== 1'b0 || dmss_rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
                n_fail++; $display("FAIL spurious_rsp cyc=%0d got i=%0b d=%0b state=%0d exp 0/0/0", c, imss_rsp_valid, dmss_rsp_valid, dbg_state);
            end
            @(posedge clk); #1;
        end
        down_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (dmss_rsp_rdata !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL spurious_rdata got=%h exp=0bad0bad", dmss_rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic        exp_d;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp_d     = k[0];
            exp_addr  = exp_d ? (32'h2000_0000 + k) : (32'h1000_0000 + k);
            exp_rdata = 32'hC0DE_0000 + k;
            run_txn(1'b1, 1'b1, 32'h1000_0000 + k, 32'h2000_0000 + k, 1'b0, 32'h0, 4'h0, 0, 0, exp_rdata, 1'b0);
            n_cmp++; if (r_gnt_d !== exp_d || r_gnt_i !== ~exp_d) begin n_fail++; $display("FAIL fair_grant k=%0d got i=%0b d=%0b exp d=%0b", k, r_gnt_i, r_gnt_d, exp_d); end
            n_cmp++; if (r_dpulse !== (exp_d ? 1 : 0) || r_ipulse !== (exp_d ? 0 : 1)) begin
                n_fail++; $display("FAIL fair_route k=%0d got i=%0d d=%0d exp d=%0b", k, r_ipulse, r_dpulse, exp_d);
            end
            n_cmp++; if (r_addr !== exp_addr || r_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL fair_data k=%0d got addr=%h rdata=%h exp addr=%h rdata=%h", k, r_addr, r_rdata, exp_addr, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_in_rsp();
        imss_req_valid = 1'b1;
        imss_req_addr  = 32'h0000_5000;
        @(negedge clk);
        n_cmp++; if (imss_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstrsp_accept got=%0b exp=1", imss_req_ready); end
        @(posedge clk); #1;
        imss_req_valid = 1'b0;
        down_req_ready = 1'b1;
        @(posedge clk); #1;
        down_req_ready = 1'b0;
        n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rstrsp_in_rsp got=%0d exp=2", dbg_state); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== 2'd0 || dbg_owner !== 1'b0 || down_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstrsp_async got state=%0d owner=%0b dvalid=%0b exp 0/0/0", dbg_state, dbg_owner, down_req_valid);
        end
        n_cmp++; if (imss_rsp_rdata !== 32'h0 || down_req_addr !== 32'h0 || imss_rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rstrsp_regs got rdata=%h addr=%h err=%0b exp 0/0/0", imss_rsp_rdata, down_req_addr, imss_rsp_err);
        end
        down_rsp_valid = 1'b1;
        down_rsp_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        down_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (imss_rsp_valid !== 1'b0 || dmss_rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL rstrsp_no_pulse cyc=%0d got i=%0b d=%0b exp 0/0", c, imss_rsp_valid, dmss_rsp_valid);
            end
            @(posedge clk); #1;
        end
        imss_req_valid = 1'b1;
        dmss_req_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (imss_req_ready !== 1'b1 || dmss_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstrsp_first_tie got i=%0b d=%0b exp i=1 d=0", imss_req_ready, dmss_req_ready);
        end
        @(posedge clk); #1;
        imss_req_valid = 1'b0;
        dmss_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_imss_read();
        test_dmss_write();
        test_req_stall();
        test_err_and_spurious();
        test_fairness();
        test_reset_in_rsp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
